// File: rtl/signext_arb_pkg.sv
// Shared types and helpers for the sign-extension arbiter.
package signext_arb_pkg;

    // Widest requester set the round-robin helper is built for.
    localparam int MAX_REQ = 32;
    localparam int MAX_IDW = 5;

    // Requester-index width for a given requester count.
    function automatic int idw_of(input int nreq);
        return (nreq <= 1) ? 1 : $clog2(nreq);
    endfunction

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } pick_t;

    // First asserted bit of valid[nreq-1:0], scanning upward from ptr and wrapping.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input int nreq, input int ptr);
        pick_t p;
        int    k;
        p = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < nreq) begin
                k = ptr + i;
                if (k >= nreq) k = k - nreq;
                if (!p.found && valid[k[MAX_IDW-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = k[MAX_IDW-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/signext.sv
// N-bit to M-bit two's-complement sign extension, purely combinational.
module signext #(
    parameter int N = 2,
    parameter int M = 5
) (
    input  logic [N-1:0] i_data,
    output logic [M-1:0] o_data
);

    // Upper bits replicate the input sign bit; low bits pass straight through.
    assign o_data = {{(M-N){i_data[N-1]}}, i_data};

endmodule

// File: rtl/signext_arb.sv
// Round-robin arbiter feeding one shared signext into a single-entry output register.
module signext_arb
    import signext_arb_pkg::*;
#(
    parameter  int N    = 2,
    parameter  int M    = 5,
    parameter  int NREQ = 4,
    localparam int IDW  = idw_of(NREQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ-1:0][N-1:0]   i_req_data,
    output logic [NREQ-1:0]          o_req_ready,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [M-1:0]             o_data,
    output logic [IDW-1:0]           o_id
);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic               o_valid_q, o_valid_d;
    logic [M-1:0]       o_data_q, o_data_d;
    logic [IDW-1:0]     o_id_q, o_id_d;

    logic               accept;
    logic               xfer;
    logic [MAX_REQ-1:0] valid_ext;
    pick_t              pick;
    logic [IDW-1:0]     gnt;
    logic [N-1:0]       gnt_data;
    logic [M-1:0]       sext_data;

    // Grant selection: the output slot is free when empty or draining this cycle.
    // Ready is suppressed during reset so nothing is accepted in the reset cycle.
    always_comb begin
        accept                 = !o_valid_q || i_ready;
        valid_ext              = '0;
        valid_ext[NREQ-1:0]    = i_req_valid;
        pick                   = rr_pick(valid_ext, NREQ, int'(ptr_q));
        gnt                    = IDW'(pick.idx);
        o_req_ready            = '0;
        if (!i_rst && accept && pick.found) o_req_ready[gnt] = 1'b1;
        xfer                   = |(i_req_valid & o_req_ready);
    end

    // Only the granted slice reaches the shared extender.
    assign gnt_data = i_req_data[gnt];

    signext #(
        .N (N),
        .M (M)
    ) u_signext (
        .i_data (gnt_data),
        .o_data (sext_data)
    );

    // Next state: load wins over drain; the pointer advances only on a transfer.
    always_comb begin
        ptr_d     = ptr_q;
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_id_d    = o_id_q;
        if (xfer) begin
            o_valid_d = 1'b1;
            o_data_d  = sext_data;
            o_id_d    = gnt;
            ptr_d     = (gnt == IDW'(NREQ-1)) ? '0 : gnt + 1'b1;
        end else if (o_valid_q && i_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a held result is discarded on reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_id_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_id_q    <= o_id_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_id    = o_id_q;

endmodule

// File: tb/tb_signext_arb.sv
// Directed plus randomized check of signext_arb against a behavioural model.
module tb_signext_arb;

    localparam int N    = 2;
    localparam int M    = 5;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0][N-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   out_valid;
    logic                   rdy;
    logic [M-1:0]           out_data;
    logic [IDW-1:0]         out_id;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_ptr   = 0;
    bit m_valid = 0;
    int m_data  = 0;
    int m_id    = 0;
    int last_acc;

    always #5 clk = ~clk;

    signext_arb #(.N(N), .M(M), .NREQ(NREQ)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_valid     (out_valid),
        .i_ready     (rdy),
        .o_data      (out_data),
        .o_id        (out_id)
    );

    // Signed value of an N-bit pattern, reduced modulo 2**M.
    function automatic int sext(input int v);
        int s;
        s = (v >= (1 << (N-1))) ? v - (1 << N) : v;
        return s & ((1 << M) - 1);
    endfunction

    function automatic int pick_ref();
        for (int i = 0; i < NREQ; i++)
            if (req_valid[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check ready before the edge, advance model, check outputs after it.
    task automatic cyc(input string tag);
        int              g;
        bit              acc;
        logic [NREQ-1:0] er;
        #1;
        acc = !m_valid || rdy;
        g   = pick_ref();
        er  = '0;
        if (!rst && acc && g >= 0) er[g] = 1'b1;
        check({tag, ".ready"}, 32'(req_ready), 32'(er));
        last_acc = -1;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0;
        end else if (acc && g >= 0) begin
            m_valid = 1; m_data = sext(int'(req_data[g])); m_id = g;
            m_ptr = (g + 1) % NREQ; last_acc = g;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".data"},  32'(out_data),  32'(m_data));
        check({tag, ".id"},    32'(out_id),    32'(m_id));
    endtask

    initial begin
        int first;
        rst = 1'b1; rdy = 1'b1; req_valid = '1;
        req_data = '0;

        // Reset with everything requesting
        cyc("rst0"); cyc("rst1");
        check("rst.valid0", 32'(out_valid), 32'd0);
        check("rst.data0",  32'(out_data),  32'd0);
        rst = 1'b0;
        cyc("rel");
        check("rel.first_id", 32'(out_id), 32'd0);

        // Single requester, sign-extension patterns
        req_valid = 4'b0100; req_data[2] = 2'b10;
        cyc("single_neg");
        check("single_neg.const", 32'(out_data), 32'b11110);
        check("single_neg.id",    32'(out_id),   32'd2);
        req_data[2] = 2'b01;
        cyc("single_pos");
        check("single_pos.const", 32'(out_data), 32'b00001);

        // Fairness: everyone valid, no bubbles
        req_valid = '1;
        for (int k = 0; k < NREQ; k++) req_data[k] = N'(k);
        cyc("fair0");
        first = int'(out_id);
        for (int i = 1; i < 6; i++) begin
            cyc("fair");
            check("fair.rot",   32'(out_id),    32'((first + i) % NREQ));
            check("fair.nobub", 32'(out_valid), 32'd1);
        end

        // Backpressure: hold three cycles, then resume rotation
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) cyc("stall");
        check("stall.ready0", 32'(req_ready), 32'd0);
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) cyc("resume");

        // Sparse wrap over requesters 1 and 3
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc("sparse");
            check("sparse.no02", 32'(req_ready & 4'b0101), 32'd0);
        end

        // Reset while a result is held under backpressure
        rdy = 1'b0;
        cyc("hold");
        rst = 1'b1;
        cyc("midrst");
        check("midrst.valid", 32'(out_valid), 32'd0);
        rst = 1'b0; rdy = 1'b1; req_valid = '1;
        cyc("after_rst");
        check("after_rst.id", 32'(out_id), 32'd0);

        // Random traffic honouring the hold-until-accepted rule
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (last_acc == k || !req_valid[k]) begin
                    req_valid[k] = ($urandom_range(0, 2) != 0);
                    req_data[k]  = N'($urandom);
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 63) == 0);
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
